// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: tag allocation, CDB/branch writeback,
// operand lookup for reservation stations, in-order commit and flush.
module reorder_buffer #(
  parameter int              ENTRIES     = 16,
  parameter int              TAG_W       = 6,
  parameter logic [TAG_W-1:0] INVALID_TAG = 6'b010000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dest,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pc,
  input  logic [31:0]      alloc_target,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb2_valid,
  input  logic [TAG_W-1:0] cdb2_tag,
  input  logic [31:0]      cdb2_data,
  input  logic             br_valid,
  input  logic [TAG_W-1:0] br_tag,
  input  logic [31:0]      br_taken,
  input  logic [TAG_W-1:0] index,
  output logic             ready,
  output logic [31:0]      value,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_dest,
  output logic [31:0]      commit_data,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;
  localparam logic [TAG_W-1:0] LIMIT = TAG_W'(ENTRIES);

  logic [IW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [ENTRIES-1:0] busy, done, is_br, pred;
  logic [4:0]         dest   [ENTRIES];
  logic [31:0]        pc     [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [31:0]        data   [ENTRIES];

  logic [IW-1:0] ci, c2i, bi, li;
  logic          cdb_hit, cdb2_hit, br_hit;
  logic          commit_fire, mispredict, alloc_fire;
  logic          unused_taken;

  assign unused_taken = ^br_taken[31:1];

  assign ci  = cdb_tag[IW-1:0];
  assign c2i = cdb2_tag[IW-1:0];
  assign bi  = br_tag[IW-1:0];
  assign li  = index[IW-1:0];

  assign cdb_hit  = cdb_valid  && (cdb_tag  < LIMIT) && busy[ci];
  assign cdb2_hit = cdb2_valid && (cdb2_tag < LIMIT) && busy[c2i];
  assign br_hit   = br_valid   && (br_tag   < LIMIT) && busy[bi];

  assign commit_fire = busy[head] && done[head];
  assign mispredict  = commit_fire && is_br[head]
                    && (data[head][0] != pred[head]);

  assign alloc_ready = (count != CW'(ENTRIES)) && !mispredict;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = {{(TAG_W-IW){1'b0}}, tail};

  always_comb begin
    ready = 1'b0;
    value = '0;
    if (index < LIMIT) begin
      if (busy[li] && done[li]) begin
        ready = 1'b1;
        value = data[li];
      end else if (cdb_valid && cdb_tag == index) begin
        ready = 1'b1;
        value = cdb_data;
      end else if (cdb2_valid && cdb2_tag == index) begin
        ready = 1'b1;
        value = cdb2_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      done         <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= INVALID_TAG;
      commit_dest  <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= commit_fire;
      flush        <= mispredict;
      // later writes win: cdb beats cdb2 beats br on a shared tag
      if (!mispredict) begin
        if (br_hit) begin
          done[bi] <= 1'b1;
          data[bi] <= {31'b0, br_taken[0]};
        end
        if (cdb2_hit) begin
          done[c2i] <= 1'b1;
          data[c2i] <= cdb2_data;
        end
        if (cdb_hit) begin
          done[ci] <= 1'b1;
          data[ci] <= cdb_data;
        end
      end
      if (commit_fire) begin
        commit_tag  <= {{(TAG_W-IW){1'b0}}, head};
        commit_dest <= is_br[head] ? 5'd0 : dest[head];
        commit_data <= data[head];
        busy[head]  <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (mispredict) begin
        busy     <= '0;
        done     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        flush_pc <= data[head][0] ? target[head] : pc[head] + 32'd4;
      end else begin
        if (alloc_fire) begin
          busy[tail]   <= 1'b1;
          done[tail]   <= 1'b0;
          dest[tail]   <= alloc_dest;
          is_br[tail]  <= alloc_is_branch;
          pred[tail]   <= alloc_pred_taken;
          pc[tail]     <= alloc_pc;
          target[tail] <= alloc_target;
          tail         <= tail + 1'b1;
        end
        count <= count + CW'(alloc_fire) - CW'(commit_fire);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios plus random
// traffic against an in-order queue model of the buffer.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_is_branch;
  logic        alloc_pred_taken;
  logic [31:0] alloc_pc;
  logic [31:0] alloc_target;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb2_valid;
  logic [5:0]  cdb2_tag;
  logic [31:0] cdb2_data;
  logic        br_valid;
  logic [5:0]  br_tag;
  logic [31:0] br_taken;
  logic [5:0]  index;
  logic        ready;
  logic [31:0] value;
  logic        commit_valid;
  logic [5:0]  commit_tag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic        flush;
  logic [31:0] flush_pc;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_is_branch(alloc_is_branch),
    .alloc_pred_taken(alloc_pred_taken),
    .alloc_pc(alloc_pc), .alloc_target(alloc_target),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag),
    .cdb2_data(cdb2_data),
    .br_valid(br_valid), .br_tag(br_tag), .br_taken(br_taken),
    .index(index), .ready(ready), .value(value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_dest(commit_dest), .commit_data(commit_data),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  dest;
    bit          br;
    bit          pred;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] data;
    bit          done;
  } ent_t;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  dest;
    logic [31:0] data;
  } cexp_t;

  ent_t        rob[$];
  int          next_tag;
  cexp_t       cq[$];
  logic [31:0] fq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find(logic [5:0] t);
    foreach (rob[i]) if (rob[i].tag == t) return i;
    return -1;
  endfunction

  function automatic bit mis_now();
    if (rob.size() == 0) return 0;
    return rob[0].done && rob[0].br && (rob[0].data[0] != rob[0].pred);
  endfunction

  task automatic wb(logic [5:0] t, logic [31:0] d);
    int k;
    ent_t e;
    if (t < 16) begin
      k = find(t);
      if (k >= 0) begin
        e = rob[k];
        e.done = 1;
        e.data = d;
        rob[k] = e;
      end
    end
  endtask

  // Monitor: pops the expected retirement whenever the DUT reports one.
  cexp_t       mon_c;
  logic [31:0] mon_f;
  always begin
    @(posedge clock);
    #2;
    if (commit_valid === 1'b1) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got tag %0h expected none",
                 commit_tag);
      end else begin
        mon_c = cq.pop_front();
        chk("commit_tag", 32'(commit_tag), 32'(mon_c.tag));
        chk("commit_dest", 32'(commit_dest), 32'(mon_c.dest));
        chk("commit_data", commit_data, mon_c.data);
      end
    end
    if (flush === 1'b1) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flush: got pc %0h expected none",
                 flush_pc);
      end else begin
        mon_f = fq.pop_front();
        chk("flush_pc", flush_pc, mon_f);
      end
    end
  end

  // One clock: check combinational outputs, advance the model, wait.
  task automatic step();
    bit          com, mis, aok, er;
    logic [31:0] ev;
    int          k;
    ent_t        e;
    cexp_t       c;
    #1;
    mis = mis_now();
    if (!reset) begin
      chk("alloc_ready", 32'(alloc_ready),
          32'(rob.size() < 16 && !mis));
      chk("alloc_tag", 32'(alloc_tag), 32'(next_tag));
      er = 0;
      ev = 0;
      if (index < 16) begin
        k = find(index);
        if (k >= 0 && rob[k].done) begin
          er = 1;
          ev = rob[k].data;
        end else if (cdb_valid && cdb_tag == index) begin
          er = 1;
          ev = cdb_data;
        end else if (cdb2_valid && cdb2_tag == index) begin
          er = 1;
          ev = cdb2_data;
        end
      end
      chk("lookup_ready", 32'(ready), 32'(er));
      chk("lookup_value", value, ev);
    end
    if (reset) begin
      rob.delete();
      next_tag = 0;
    end else begin
      com = rob.size() > 0 && rob[0].done;
      aok = rob.size() < 16 && !mis;
      if (com) begin
        c.tag  = rob[0].tag;
        c.dest = rob[0].br ? 5'd0 : rob[0].dest;
        c.data = rob[0].data;
        cq.push_back(c);
      end
      if (mis)
        fq.push_back(rob[0].data[0] ? rob[0].target : rob[0].pc + 32'd4);
      if (!mis) begin
        if (br_valid) wb(br_tag, {31'b0, br_taken[0]});
        if (cdb2_valid) wb(cdb2_tag, cdb2_data);
        if (cdb_valid) wb(cdb_tag, cdb_data);
      end
      if (mis) begin
        rob.delete();
        next_tag = 0;
      end else begin
        if (com) void'(rob.pop_front());
        if (alloc_valid && aok) begin
          e.tag    = 6'(next_tag);
          e.dest   = alloc_dest;
          e.br     = alloc_is_branch;
          e.pred   = alloc_pred_taken;
          e.pc     = alloc_pc;
          e.target = alloc_target;
          e.data   = 0;
          e.done   = 0;
          rob.push_back(e);
          next_tag = (next_tag + 1) % 16;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    alloc_valid      = 0;
    alloc_dest       = 0;
    alloc_is_branch  = 0;
    alloc_pred_taken = 0;
    alloc_pc         = 0;
    alloc_target     = 0;
    cdb_valid        = 0;
    cdb_tag          = 0;
    cdb_data         = 0;
    cdb2_valid       = 0;
    cdb2_tag         = 0;
    cdb2_data        = 0;
    br_valid         = 0;
    br_tag           = 0;
    br_taken         = 0;
    index            = 0;
  endtask

  task automatic alloc(logic [4:0] d, bit b, bit p,
                       logic [31:0] a, logic [31:0] t);
    alloc_valid      = 1;
    alloc_dest       = d;
    alloc_is_branch  = b;
    alloc_pred_taken = p;
    alloc_pc         = a;
    alloc_target     = t;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_cv"}, 32'(commit_valid), 0);
    chk({n, "_ctag"}, 32'(commit_tag), 32'h10);
    chk({n, "_cdest"}, 32'(commit_dest), 0);
    chk({n, "_cdata"}, commit_data, 0);
    chk({n, "_flush"}, 32'(flush), 0);
    chk({n, "_fpc"}, flush_pc, 0);
  endtask

  int k;
  int ph;

  initial begin
    idle();
    reset = 1;
    next_tag = 0;
    @(negedge clock);
    step();
    do_reset();
    chk_reset_outs("rst");

    // ALU entries, out-of-order results, in-order retirement
    alloc(5, 0, 0, 32'h10, 0);
    #1 chk("t1_tag0", 32'(alloc_tag), 0);
    step();
    alloc(6, 0, 0, 32'h14, 0);
    #1 chk("t1_tag1", 32'(alloc_tag), 1);
    step();
    alloc(7, 0, 0, 32'h18, 0);
    step();
    idle();
    cdb_valid = 1; cdb_tag = 1; cdb_data = 32'hAA;
    step();
    cdb_tag = 0; cdb_data = 32'h55;
    step();
    idle();
    chk("t1_none_yet", 32'(commit_valid), 0);
    step();
    chk("t1_c0_valid", 32'(commit_valid), 1);
    chk("t1_c0_data", commit_data, 32'h55);
    chk("t1_c0_dest", 32'(commit_dest), 5);
    step();
    chk("t1_c1_tag", 32'(commit_tag), 1);
    chk("t1_c1_data", commit_data, 32'hAA);
    step();
    chk("t1_tag2_waits", 32'(commit_valid), 0);

    // Lookup: forwarding, out-of-range and pending entries
    index = 2; cdb_valid = 1; cdb_tag = 2; cdb_data = 32'h1234;
    #1;
    chk("t2_fwd_ready", 32'(ready), 1);
    chk("t2_fwd_value", value, 32'h1234);
    step();
    idle();
    index = 16;
    #1 chk("t2_idx16", 32'(ready), 0);
    alloc(9, 0, 0, 32'h1C, 0);
    step();
    idle();
    index = 3;
    #1 chk("t2_pending", 32'(ready), 0);
    step();
    do_reset();

    // Fill to full, retire one, wrap allocation to tag 0
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), 0, 0, 32'(i * 4), 0);
      step();
    end
    idle();
    #1 chk("t3_full", 32'(alloc_ready), 0);
    alloc(20, 0, 0, 32'h400, 0);
    cdb_valid = 1; cdb_tag = 0; cdb_data = 32'hF0;
    step();
    cdb_valid = 0;
    #1 chk("t3_full_commit", 32'(alloc_ready), 0);
    step();
    #1;
    chk("t3_freed", 32'(alloc_ready), 1);
    chk("t3_wrap_tag", 32'(alloc_tag), 0);
    step();
    idle();
    #1 chk("t3_after_wrap", 32'(alloc_tag), 1);
    step();
    do_reset();

    // Mispredicted branch at head flushes younger done entries
    alloc(0, 1, 0, 32'h100, 32'h200);
    step();
    alloc(3, 0, 0, 32'h104, 0);
    step();
    alloc(4, 0, 0, 32'h108, 0);
    step();
    idle();
    cdb_valid = 1; cdb_tag = 1; cdb_data = 1;
    cdb2_valid = 1; cdb2_tag = 2; cdb2_data = 2;
    br_valid = 1; br_tag = 0; br_taken = 1;
    step();
    idle();
    alloc(8, 0, 0, 32'h10C, 0);
    #1 chk("t4_no_alloc", 32'(alloc_ready), 0);
    step();
    idle();
    chk("t4_flush", 32'(flush), 1);
    chk("t4_flush_pc", flush_pc, 32'h200);
    chk("t4_commit", 32'(commit_valid), 1);
    chk("t4_dest0", 32'(commit_dest), 0);
    #1 chk("t4_tag_reset", 32'(alloc_tag), 0);
    step();
    step();
    chk("t4_no_young", 32'(commit_valid), 0);
    chk("t4_flush_drop", 32'(flush), 0);
    do_reset();

    // Correct branch, then not-taken mispredict with junk upper bits
    alloc(9, 1, 1, 32'h300, 32'h400);
    step();
    idle();
    br_valid = 1; br_tag = 0; br_taken = 1;
    step();
    idle();
    step();
    chk("t5_commit", 32'(commit_valid), 1);
    chk("t5_dest", 32'(commit_dest), 0);
    chk("t5_noflush", 32'(flush), 0);
    alloc(0, 1, 1, 32'h100, 32'h500);
    step();
    idle();
    br_valid = 1; br_tag = 1; br_taken = 32'hFFFF_FFFE;
    step();
    idle();
    step();
    chk("t5_flush", 32'(flush), 1);
    chk("t5_flush_pc", flush_pc, 32'h104);
    do_reset();

    // Dual-port collision, then reset with live entries
    for (int i = 0; i < 4; i++) begin
      alloc(5'(i + 1), 0, 0, 32'(i * 4), 0);
      step();
    end
    idle();
    cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h11;
    cdb2_valid = 1; cdb2_tag = 3; cdb2_data = 32'h22;
    step();
    idle();
    index = 3;
    #1;
    chk("t6_prio_ready", 32'(ready), 1);
    chk("t6_prio_value", value, 32'h11);
    step();
    do_reset();
    chk_reset_outs("t6");
    index = 3;
    #1;
    chk("t6_tag0", 32'(alloc_tag), 0);
    chk("t6_cleared", 32'(ready), 0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      ph = (c / 250) % 2;
      idle();
      reset = ($urandom % 600 == 0);
      alloc_valid = ($urandom % 4) < (ph == 0 ? 3 : 1);
      alloc_dest = 5'($urandom);
      alloc_is_branch = ($urandom % 5 == 0);
      alloc_pred_taken = 1'($urandom);
      alloc_pc = $urandom & 32'hFFFF_FFFC;
      alloc_target = $urandom;
      if (rob.size() > 0 && $urandom % (ph == 1 ? 2 : 4) == 0) begin
        k = $urandom_range(0, rob.size() - 1);
        if (!rob[k].br) begin
          cdb_valid = 1;
          cdb_tag = rob[k].tag;
        end
      end
      if (rob.size() > 0 && $urandom % (ph == 1 ? 2 : 4) == 0) begin
        k = $urandom_range(0, rob.size() - 1);
        if (!rob[k].br) begin
          cdb2_valid = 1;
          cdb2_tag = rob[k].tag;
        end
      end
      if ($urandom % 16 == 0) begin
        cdb_valid = 1;
        cdb_tag = 6'($urandom_range(0, 63));
      end
      cdb_data = $urandom;
      cdb2_data = $urandom;
      if (rob.size() > 0 && $urandom % 3 == 0) begin
        k = $urandom_range(0, rob.size() - 1);
        if (rob[k].br) begin
          br_valid = 1;
          br_tag = rob[k].tag;
          br_taken = $urandom;
          br_taken[0] = ($urandom % 8 == 0) ? ~rob[k].pred : rob[k].pred;
        end
      end
      if ($urandom % 4 == 0) index = cdb_tag;
      else if (rob.size() > 0 && $urandom % 2 == 0)
        index = rob[$urandom_range(0, rob.size() - 1)].tag;
      else index = 6'($urandom_range(0, 20));
      step();
    end
    reset = 0;

    // Drain whatever is left
    for (int c = 0; c < 40; c++) begin
      idle();
      if (rob.size() > 0) begin
        if (rob[0].br) begin
          br_valid = 1;
          br_tag = rob[0].tag;
          br_taken = 32'(rob[0].pred);
        end else begin
          cdb_valid = 1;
          cdb_tag = rob[0].tag;
          cdb_data = $urandom;
        end
      end
      step();
    end
    idle();
    step();
    step();
    chk("scoreboard_empty", 32'(cq.size() + fq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer: allocates a tag per dispatched instruction, captures results from both CDB ports and from the branch reservation station, and commits in order.
- Serves as the responder for reservation-station operand lookups: RS drives index, ROB returns ready/value.
- On commit of a mispredicted branch it flushes all in-flight entries and redirects fetch.

Parameters:
ENTRIES, 16, number of ROB entries; tags are 0..ENTRIES-1.
TAG_W, 6, width of ROB tag and lookup index.
INVALID_TAG, 6'b010000, "no producer" tag value; never allocated.

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state on posedge
alloc_valid  in  1  dispatch requests an entry this cycle
alloc_dest  in  5  architectural destination register; 0 means no writeback
alloc_is_branch  in  1  entry is a conditional branch
alloc_pred_taken  in  1  predicted direction (branches only)
alloc_pc  in  32  instruction PC
alloc_target  in  32  branch taken-target
alloc_ready  out  1  combinational: entry can be allocated this cycle
alloc_tag  out  6  combinational: tag the next allocation receives (= tail)
cdb_valid  in  1  CDB port 1 broadcast
cdb_tag  in  6  CDB port 1 tag
cdb_data  in  32  CDB port 1 data
cdb2_valid  in  1  CDB port 2 broadcast
cdb2_tag  in  6  CDB port 2 tag
cdb2_data  in  32  CDB port 2 data
br_valid  in  1  branch result from branch RS
br_tag  in  6  branch entry tag
br_taken  in  32  1 = taken, 0 = not taken (bit 0 significant)
index  in  6  operand lookup tag
ready  out  1  combinational: value for index is available
value  out  32  combinational: value for index
commit_valid  out  1  registered, one-cycle pulse per retired entry
commit_tag  out  6  registered, tag of retired entry
commit_dest  out  5  registered, destination (0 for branches)
commit_data  out  32  registered, result data
flush  out  1  registered, one-cycle pulse after mispredicted branch retires
flush_pc  out  32  registered redirect PC

Behaviour:
- State: head, tail (4-bit, wrap 15->0), count (0..16). Per entry: busy, done, dest, is_branch, pred_taken, pc, target, data.
- Reset: all busy/done = 0, head = tail = count = 0. Outputs: commit_valid = 0, commit_tag = INVALID_TAG, commit_dest = 0, commit_data = 0, flush = 0, flush_pc = 0. Reset overrides every other event in that cycle, including a pending flush.
- alloc_ready = (count != 16) and no mispredict commit this cycle. alloc_tag = {2'b00, tail}.
- Allocation on posedge when alloc_valid and alloc_ready: entry[tail] gets busy = 1, done = 0, and the fields. tail increments; count increments unless a commit happens in the same cycle.
- Writeback on posedge: for each of cdb, cdb2, br with valid and tag < 16 and entry busy, set done = 1 and data (br: data = {31'b0, br_taken[0]}).
- Writebacks with tag >= 16 or to a non-busy entry are ignored.
- Same-tag collision on one edge: priority is cdb > cdb2 > br.
- Lookup (combinational), checked in order:
  - index >= 16: ready = 0, value = 0.
  - Entry busy and done: ready = 1, value = data.
  - Otherwise, same-cycle forwarding: cdb_valid with cdb_tag == index gives cdb_data, else cdb2_valid with matching tag gives cdb2_data.
  - Otherwise ready = 0, value = 0.
- Commit: at most one per cycle, when entry[head] is busy and done.
  - On posedge: entry cleared, head increments, count decrements unless an allocation happens in the same cycle.
  - Next cycle: commit_valid = 1, commit_tag = head, commit_dest = dest (0 if is_branch), commit_data = data.
  - Commit latency: result written at edge N, retired at edge N+1 at the earliest (done is registered).
- Mispredict: a committing branch whose data[0] != pred_taken.
  - At that edge: the branch still commits, all entries are cleared, head = tail = count = 0.
  - Next cycle: flush = 1, flush_pc = taken ? target : pc + 4 (32-bit wrap).
  - alloc_ready is 0 in the mispredict cycle, so no dispatch is lost.
  - Writebacks in that cycle are discarded.
- Correct branch: normal commit, flush = 0.
- Full: count = 16, alloc_ready = 0. A commit in that cycle does not enable allocation until the next cycle.
- Empty: count = 0, no commit. Allocation and writeback to the same tag on the same edge is impossible, because the tag was not yet issued.

Test Plan:
1. Reset, then allocate 3 ALU entries (dest 5, 6, 7) -> alloc_tag 0, 1, 2. CDB tag 1 = 0xAA, then tag 0 = 0x55 -> commits tag 0 (0x55, dest 5) then tag 1 (0xAA, dest 6) on consecutive cycles; tag 2 waits.
2. Lookup: index 2 while cdb_valid with tag 2 = 0x1234 -> ready = 1, value = 0x1234 the same cycle. index = 16 -> ready = 0. index = busy non-done tag -> ready = 0.
3. Fill 16 entries -> alloc_ready = 0 at count 16. Commit one -> alloc_ready = 1 next cycle. Allocation wraps to tag 0.
4. Branch at head: pc 0x100, target 0x200, pred 0, br_taken = 1 -> flush pulse with flush_pc = 0x200, count = 0, younger entries never commit, alloc_tag = 0.
5. Branch pred 1, br_taken = 1 -> commit_valid = 1, commit_dest = 0, flush stays 0. Branch pc 0x100, pred 1, br_taken = 0 -> flush_pc = 0x104.
6. cdb and cdb2 both tag 3 (0x11 / 0x22) -> entry 3 data = 0x11. Assert reset while entries are busy -> all outputs return to reset values the next cycle.
